// File: rtl/layer_scheduler.sv
// Layer scheduler: walks a small base-address table, kicking the conv engine once per layer
// and checking each layer's result-write count and completion time.
module layer_scheduler #(
    parameter int unsigned NUM_LAYERS    = 4,
    parameter logic [15:0] TIMEOUT       = 16'hFFFF,
    parameter logic [12:0] OUT_PER_LAYER = 13'd4704
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  num_layers,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_idx,
    input  logic [30:0] cfg_data,
    output logic        eng_start,
    output logic [9:0]  eng_img_base,
    output logic [7:0]  eng_w_base,
    output logic [12:0] eng_out_base,
    input  logic        eng_valid,
    input  logic        eng_done,
    output logic        busy,
    output logic        done,
    output logic [2:0]  layer_idx,
    output logic        timeout_err,
    output logic        cnt_err
);

    typedef enum logic [2:0] {Idle, Load, Kick, Wait, Next, Finish} state_e;

    state_e      state_q;
    logic [30:0] tbl_q [NUM_LAYERS];
    logic [2:0]  num_q;
    logic [15:0] timer_q;
    logic [12:0] out_cnt_q;
    logic [12:0] out_cnt_inc;
    logic        start_ok;

    assign start_ok    = (num_layers != 3'd0) && (32'(num_layers) <= NUM_LAYERS);
    // Count including a write landing in the same cycle as eng_done; saturates.
    assign out_cnt_inc = (eng_valid && (out_cnt_q != 13'h1FFF)) ? out_cnt_q + 13'd1 : out_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_we && (state_q == Idle) && (32'(cfg_idx) < NUM_LAYERS)) begin
            tbl_q[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= Idle;
            num_q        <= '0;
            timer_q      <= '0;
            out_cnt_q    <= '0;
            eng_start    <= 1'b0;
            eng_img_base <= '0;
            eng_w_base   <= '0;
            eng_out_base <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            layer_idx    <= '0;
            timeout_err  <= 1'b0;
            cnt_err      <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            done      <= 1'b0;
            if (abort && (state_q != Idle)) begin
                state_q <= Idle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    Idle: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (start_ok) begin
                                num_q       <= num_layers;
                                layer_idx   <= '0;
                                timeout_err <= 1'b0;
                                cnt_err     <= 1'b0;
                                state_q     <= Load;
                            end else begin
                                state_q <= Finish;
                            end
                        end
                    end
                    Load: begin
                        {eng_img_base, eng_w_base, eng_out_base} <= tbl_q[layer_idx[1:0]];
                        // Registered here so the pulse is high exactly while in Kick.
                        eng_start <= 1'b1;
                        state_q   <= Kick;
                    end
                    Kick: begin
                        timer_q   <= '0;
                        out_cnt_q <= '0;
                        state_q   <= Wait;
                    end
                    Wait: begin
                        out_cnt_q <= out_cnt_inc;
                        if (eng_done) begin
                            if (out_cnt_inc != OUT_PER_LAYER) begin
                                cnt_err <= 1'b1;
                            end
                            state_q <= Next;
                        end else if (timer_q == TIMEOUT) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state_q     <= Idle;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                    Next: begin
                        if (layer_idx == num_q - 3'd1) begin
                            state_q <= Finish;
                        end else begin
                            layer_idx <= layer_idx + 3'd1;
                            state_q   <= Load;
                        end
                    end
                    Finish: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= Idle;
                    end
                    default: state_q <= Idle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: directed and randomized layer sequences against a table model.
module tb_layer_scheduler;

    localparam int OPL = 4704;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
    logic        eng_valid = 1'b0, eng_done = 1'b0;
    logic [2:0]  num_layers = '0;
    logic [1:0]  cfg_idx = '0;
    logic [30:0] cfg_data = '0;

    logic        eng_start, busy, done, timeout_err, cnt_err;
    logic [9:0]  eng_img_base;
    logic [7:0]  eng_w_base;
    logic [12:0] eng_out_base;
    logic [2:0]  layer_idx;

    logic        t_eng_start, t_busy, t_done, t_timeout_err, t_cnt_err;
    logic [9:0]  t_img;
    logic [7:0]  t_w;
    logic [12:0] t_out;
    logic [2:0]  t_layer_idx;

    layer_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_layers(num_layers),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .eng_start(eng_start),
        .eng_img_base(eng_img_base), .eng_w_base(eng_w_base), .eng_out_base(eng_out_base),
        .eng_valid(eng_valid), .eng_done(eng_done), .busy(busy), .done(done),
        .layer_idx(layer_idx), .timeout_err(timeout_err), .cnt_err(cnt_err)
    );

    // Second instance with a short timeout and an engine that never answers.
    layer_scheduler #(.TIMEOUT(16'd100)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_layers(num_layers),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .eng_start(t_eng_start),
        .eng_img_base(t_img), .eng_w_base(t_w), .eng_out_base(t_out),
        .eng_valid(1'b0), .eng_done(1'b0), .busy(t_busy), .done(t_done),
        .layer_idx(t_layer_idx), .timeout_err(t_timeout_err), .cnt_err(t_cnt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [30:0] seen_q[$];
    int done_cnt = 0, done_cyc = 0, t_start_cyc = 0, t_to_cyc = 0, t_done_cnt = 0;
    logic t_to_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_start) seen_q.push_back({eng_img_base, eng_w_base, eng_out_base});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (t_eng_start) t_start_cyc = cyc;
            if (t_timeout_err && !t_to_prev) t_to_cyc = cyc;
            if (t_done) t_done_cnt++;
        end
        t_to_prev = t_timeout_err;
    end

    int vectors = 0, miscompares = 0;
    logic [30:0] tbl [4];
    int start_cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(int n);
        start = 1'b1;
        num_layers = 3'(n);
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic write_cfg(int idx, logic [30:0] data);
        cfg_we = 1'b1;
        cfg_idx = 2'(idx);
        cfg_data = data;
        step();
        cfg_we = 1'b0;
        tbl[idx] = data;
    endtask

    task automatic wait_kick(string tag, output int kick_cyc);
        for (int w = 0; w < 10 && !eng_start; w++) step();
        check({tag, ":kick_seen"}, 32'(eng_start), 32'd1);
        kick_cyc = cyc;
    endtask

    // Engine model for one layer: n result writes, eng_done either with the last one or after.
    task automatic engine_layer(string tag, int n, bit tog, bit gaps, bit inject,
                                output int kick_cyc);
        wait_kick(tag, kick_cyc);
        step();
        if (inject) begin
            // Busy: both the table write and the new start must be ignored.
            cfg_we = 1'b1; cfg_idx = 2'd1; cfg_data = ~tbl[1];
            start = 1'b1; num_layers = 3'd1;
            step();
            cfg_we = 1'b0; start = 1'b0; num_layers = 3'd2;
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) step();
            eng_valid = 1'b1;
            eng_done = tog && (i == n - 1);
            step();
            eng_valid = 1'b0;
            eng_done = 1'b0;
        end
        if (!tog) begin
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
        end
    endtask

    task automatic run_seq(string tag, int nl, int cnts[4], bit tog[4], bit gaps, bit inject);
        int q0 = seen_q.size();
        int d0 = done_cnt;
        int kc;
        bit exp_cerr = 1'b0;
        do_start(nl);
        for (int l = 0; l < nl; l++) begin
            engine_layer(tag, cnts[l], tog[l], gaps, inject && (l == 0), kc);
            if (l == 0) check({tag, ":kick_latency"}, 32'(kc - start_cyc), 32'd2);
            exp_cerr |= (cnts[l] != OPL);
        end
        repeat (6) step();
        check({tag, ":kicks"}, 32'(seen_q.size() - q0), 32'(nl));
        for (int l = 0; l < nl; l++)
            if (seen_q.size() > q0 + l) check({tag, ":bases"}, 32'(seen_q[q0 + l]), 32'(tbl[l]));
        check({tag, ":done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, ":cnt_err"}, 32'(cnt_err), 32'(exp_cerr));
        check({tag, ":timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, ":busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnts[4];
        bit tog[4];
        int q0, d0, kc, nl;

        for (int i = 0; i < 4; i++) tbl[i] = '0;
        #2;
        check("reset_ctrl", {26'd0, busy, done, eng_start, layer_idx, timeout_err, cnt_err},
              32'd0);
        check("reset_bases", {1'b0, eng_img_base, eng_w_base, eng_out_base}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Two programmed layers, exact write counts; start and cfg_we mid-run are ignored.
        for (int i = 0; i < 4; i++) write_cfg(i, 31'($urandom));
        cnts = '{OPL, OPL, OPL, OPL};
        tog = '{1'b1, 1'b0, 1'b1, 1'b0};
        run_seq("two_layers", 2, cnts, tog, 1'b0, 1'b1);

        // Abort in the same cycle as layer 0's eng_done of a 3-layer run.
        q0 = seen_q.size();
        d0 = done_cnt;
        do_start(3);
        wait_kick("abort", kc);
        step();
        repeat (10) begin
            eng_valid = 1'b1;
            step();
        end
        eng_valid = 1'b0;
        eng_done = 1'b1;
        abort = 1'b1;
        step();
        eng_done = 1'b0;
        abort = 1'b0;
        repeat (10) step();
        check("abort:kicks", 32'(seen_q.size() - q0), 32'd1);
        check("abort:done", 32'(done_cnt - d0), 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:cnt_err", 32'(cnt_err), 32'd0);
        write_cfg(0, 31'($urandom));

        // One layer short by one write.
        cnts = '{OPL - 1, OPL, OPL, OPL};
        tog = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_seq("short_layer", 1, cnts, tog, 1'b0, 1'b0);

        // Invalid layer counts go straight to FINISH; a start during FINISH is ignored.
        q0 = seen_q.size();
        d0 = done_cnt;
        do_start(0);
        start = 1'b1;
        num_layers = 3'd2;
        step();
        start = 1'b0;
        repeat (4) step();
        check("zero:done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check("zero:done", 32'(done_cnt - d0), 32'd1);
        check("zero:kicks", 32'(seen_q.size() - q0), 32'd0);
        check("zero:cnt_err_kept", 32'(cnt_err), 32'd1);
        d0 = done_cnt;
        do_start(5);
        repeat (4) step();
        check("over:done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check("over:done", 32'(done_cnt - d0), 32'd1);
        check("over:kicks", 32'(seen_q.size() - q0), 32'd0);
        d0 = done_cnt;
        do_start(0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        check("fin_abort:done", 32'(done_cnt - d0), 32'd0);
        check("fin_abort:cnt_err", 32'(cnt_err), 32'd1);

        // Randomized tables, layer counts, write counts and pacing.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) write_cfg(i, 31'($urandom));
            nl = $urandom_range(1, 2);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0, 1: cnts[i] = OPL;
                    2: cnts[i] = OPL + $urandom_range(1, 3);
                    default: cnts[i] = OPL - $urandom_range(1, 30);
                endcase
                tog[i] = 1'($urandom_range(0, 1));
            end
            run_seq("random", nl, cnts, tog, 1'b1, 1'b0);
        end

        // Reset during WAIT clears outputs without a clock edge, and clears the table.
        d0 = done_cnt;
        do_start(1);
        wait_kick("rst_mid", kc);
        step();
        eng_valid = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid:ctrl", {26'd0, busy, done, eng_start, layer_idx, timeout_err, cnt_err},
              32'd0);
        check("rst_mid:bases", {1'b0, eng_img_base, eng_w_base, eng_out_base}, 32'd0);
        eng_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid:done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        q0 = seen_q.size();
        do_start(1);
        wait_kick("rst_tbl", kc);
        step();
        if (seen_q.size() > q0) check("rst_tbl:base", 32'(seen_q[q0]), 32'(tbl[0]));
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // Timeout on the short-timeout instance.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        d0 = t_done_cnt;
        do_start(1);
        for (int i = 0; i < 130 && !t_timeout_err; i++) step();
        step();
        check("timeout:flag", 32'(t_timeout_err), 32'd1);
        check("timeout:latency_ok",
              32'((t_to_cyc - t_start_cyc >= 98) && (t_to_cyc - t_start_cyc <= 106)), 32'd1);
        check("timeout:busy", 32'(t_busy), 32'd0);
        check("timeout:done", 32'(t_done_cnt - d0), 32'd0);
        check("timeout:main_no_flag", 32'(timeout_err), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("timeout:main_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
